// File: rtl/kul_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro KUL_SEQ_DIVIDER_APPROX_EN zeroes the divisor's APPROX_LSB low bits at accept.
module kul_seq_divider #(
  parameter int DW         = 16,
  parameter int VW         = 8,
  parameter int APPROX_LSB = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          div_by_zero_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  if (APPROX_LSB >= VW) begin : g_bad_approx_lsb
    $error("APPROX_LSB must be smaller than VW");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_eff;
  logic [VW-1:0] r_q, r_d;
  logic [VW:0]   r_shift;
  logic [CW-1:0] cnt_q;

`ifdef KUL_SEQ_DIVIDER_APPROX_EN
  localparam logic [VW-1:0] LSB_MASK = VW'((1 << APPROX_LSB) - 1);
  logic [VW-1:0] d_masked;
  assign d_masked = divisor_i & ~LSB_MASK;
  // Small divisors that mask to zero fall back to the exact value.
  assign d_eff    = (d_masked != '0) ? d_masked : divisor_i;
`else
  assign d_eff = divisor_i;
`endif

  // The extra bit lives only in the shifted value; the stored remainder is always < D.
  always_comb begin
    r_shift = {r_q, q_q[DW-1]};
    if (r_shift >= {1'b0, d_q}) begin
      r_d = VW'(r_shift - {1'b0, d_q});
      q_d = {q_q[DW-2:0], 1'b1};
    end else begin
      r_d = r_shift[VW-1:0];
      q_d = {q_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      in_ready_o    <= 1'b1;
      out_valid_o   <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      cnt_q         <= '0;
      q_q           <= '0;
      d_q           <= '0;
      r_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            q_q        <= dividend_i;
            d_q        <= d_eff;
            r_q        <= '0;
            cnt_q      <= CW'(DW - 1);
            in_ready_o <= 1'b0;
            if (divisor_i == '0) begin
              state_q       <= DONE;
              out_valid_o   <= 1'b1;
              quotient_o    <= '1;
              remainder_o   <= dividend_i[VW-1:0];
              div_by_zero_o <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == '0) begin
            state_q       <= DONE;
            out_valid_o   <= 1'b1;
            quotient_o    <= q_d;
            remainder_o   <= r_d;
            div_by_zero_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kul_seq_divider.sv
// Bench for kul_seq_divider: directed cases plus randomized operands against an arithmetic model.
module tb_kul_seq_divider;
  localparam int DW         = 16;
  localparam int VW         = 8;
  localparam int APPROX_LSB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kul_seq_divider #(.DW(DW), .VW(VW), .APPROX_LSB(APPROX_LSB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Integer-division reference, including the approximate divisor rule when compiled in.
  task automatic ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
    int unsigned eff;
    int unsigned ai;
    ai  = a;
    eff = b;
`ifdef KUL_SEQ_DIVIDER_APPROX_EN
    eff = (eff >> APPROX_LSB) << APPROX_LSB;
    if (eff == 0) eff = b;
`endif
    if (b == 0) begin
      q = '1;
      r = a[VW-1:0];
      z = 1'b1;
    end else begin
      q = DW'(ai / eff);
      r = VW'(ai % eff);
      z = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int            lat;
    ref_div(a, b, eq, er, ez);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "/latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(DW + 1));
    chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
    chk({tag, "/quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "/remainder"}, 32'(remainder), 32'(er));
    chk({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "/hold_quotient"}, 32'(quotient), 32'(eq));
      chk({tag, "/hold_remainder"}, 32'(remainder), 32'(er));
      chk({tag, "/hold_dbz"}, 32'(div_by_zero), 32'(ez));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "/quotient_kept"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/quotient", 32'(quotient), 32'd0);
    chk("reset/remainder", 32'(remainder), 32'd0);
    chk("reset/dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("1000_7", 16'd1000, 8'd7, 0);
    run_op("65535_255", 16'd65535, 8'd255, 0);
    run_op("3_200", 16'd3, 8'd200, 0);
    run_op("10_3", 16'd10, 8'd3, 0);
    run_op("1000_7_bp", 16'd1000, 8'd7, 5);
    run_op("5_0", 16'd5, 8'd0, 2);

    // Abort during RUN: accept edge plus seven more edges, reset lands on RUN cycle 8.
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/quotient", 32'(quotient), 32'd0);
    chk("abort/remainder", 32'(remainder), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort/no_result", 32'(out_valid), 32'd0);
    run_op("100_9", 16'd100, 8'd9, 0);

    for (int n = 0; n < 40; n++) begin
      ra = DW'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = VW'($urandom_range(1, 3));
        default: rb = VW'($urandom);
      endcase
      run_op("rand", ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
